// File: rtl/ysyx_22050133_div_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states, helpers.
package ysyx_22050133_div_pkg;

    localparam int YSYX_22050133_XLEN = 64;

    localparam logic [1:0] YSYX_22050133_OP_DIV  = 2'b00;
    localparam logic [1:0] YSYX_22050133_OP_DIVU = 2'b01;
    localparam logic [1:0] YSYX_22050133_OP_REM  = 2'b10;
    localparam logic [1:0] YSYX_22050133_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        YSYX_22050133_ST_IDLE = 2'd0,
        YSYX_22050133_ST_BUSY = 2'd1,
        YSYX_22050133_ST_DONE = 2'd2
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == YSYX_22050133_OP_DIV) || (op == YSYX_22050133_OP_REM);
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050133_div_if.sv
// Request/response bundle between the EXU (master) and the divider (slave).
// Handshake: a request transfers on a rising edge with in_valid && in_ready && !flush;
// a result transfers on a rising edge with out_valid && out_ready; flush kills both.
interface ysyx_22050133_div_if #(
    parameter int XLEN = 64
) ();
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic            word;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, word, dividend, divisor, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, word, dividend, divisor, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/ysyx_22050133_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract, select.
module ysyx_22050133_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvs,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quo
);
    logic [XLEN+1:0] w_shift;
    logic [XLEN+1:0] w_diff;
    logic            w_ge;

    // One guard bit above the 65-bit partial remainder makes the borrow the select signal.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {2'b00, i_dvs};
    assign w_ge    = ~w_diff[XLEN+1];
    assign o_rem   = w_ge ? w_diff[XLEN:0] : w_shift[XLEN:0];
    assign o_quo   = {i_quo[XLEN-2:0], w_ge};
endmodule

// File: rtl/ysyx_22050133_div.sv
// Multi-cycle RV64 divider (DIV/DIVU/REM/REMU and W forms), IDLE/BUSY/DONE FSM.
// Define YSYX_22050133_DIV_EARLY_EN to finish divide-by-zero and signed overflow right after accept.
module ysyx_22050133_div
    import ysyx_22050133_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22050133_div_if.slave    bus,
    output div_state_e            o_dbg_state
);
    div_state_e      r_state, w_next;
    logic [6:0]      r_cnt;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo, r_dvs, r_ext_a;
    logic            r_is_rem, r_word, r_neg_q, r_neg_r, r_dz, r_ovf;

    logic            w_sgn, w_a_neg, w_b_neg, w_dz, w_ovf, w_accept;
    logic [XLEN-1:0] w_a, w_b, w_a_mag, w_b_mag;
    logic [XLEN:0]   w_step_rem;
    logic [XLEN-1:0] w_step_quo;
    logic [XLEN-1:0] w_q, w_r, w_sel, w_res;

    // Operands as the instruction sees them: W forms use the low word, extended by signedness.
    always_comb begin
        w_sgn   = op_is_signed(bus.op);
        w_a     = bus.word ? (w_sgn ? sext32(bus.dividend[31:0]) : {32'b0, bus.dividend[31:0]})
                           : bus.dividend;
        w_b     = bus.word ? (w_sgn ? sext32(bus.divisor[31:0]) : {32'b0, bus.divisor[31:0]})
                           : bus.divisor;
        w_a_neg = w_sgn & w_a[XLEN-1];
        w_b_neg = w_sgn & w_b[XLEN-1];
        w_a_mag = w_a_neg ? -w_a : w_a;
        w_b_mag = w_b_neg ? -w_b : w_b;
        w_dz    = (w_b == '0);
        w_ovf   = w_sgn && (w_b == '1) &&
                  (bus.word ? (w_a == 64'hFFFF_FFFF_8000_0000) : (w_a == {1'b1, {(XLEN-1){1'b0}}}));
    end

    assign w_accept = bus.in_valid && (r_state == YSYX_22050133_ST_IDLE) && !bus.flush;

`ifdef YSYX_22050133_DIV_EARLY_EN
    logic w_special;
    assign w_special = w_dz | w_ovf;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            YSYX_22050133_ST_IDLE: begin
                if (w_accept) begin
`ifdef YSYX_22050133_DIV_EARLY_EN
                    w_next = w_special ? YSYX_22050133_ST_DONE : YSYX_22050133_ST_BUSY;
`else
                    w_next = YSYX_22050133_ST_BUSY;
`endif
                end
            end
            YSYX_22050133_ST_BUSY: if (r_cnt == 7'd1) w_next = YSYX_22050133_ST_DONE;
            YSYX_22050133_ST_DONE: if (bus.out_ready) w_next = YSYX_22050133_ST_IDLE;
            default:               w_next = YSYX_22050133_ST_IDLE;
        endcase
        if (bus.flush) w_next = YSYX_22050133_ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= YSYX_22050133_ST_IDLE;
        else     r_state <= w_next;
    end

    ysyx_22050133_div_step #(.XLEN(XLEN)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // W forms park the 32-bit magnitude in the upper half so 32 steps consume it fully.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_ext_a  <= '0;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= bus.word ? 7'd32 : 7'd64;
            r_rem    <= '0;
            r_quo    <= bus.word ? {w_a_mag[31:0], 32'b0} : w_a_mag;
            r_dvs    <= w_b_mag;
            r_ext_a  <= w_a;
            r_is_rem <= bus.op[1];
            r_word   <= bus.word;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= w_dz;
            r_ovf    <= w_ovf;
        end else if (r_state == YSYX_22050133_ST_BUSY) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt - 7'd1;
        end
    end

    // Special cases override the magnitude result, so iterating over them is harmless.
    always_comb begin
        w_q = r_neg_q ? -r_quo : r_quo;
        w_r = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
        if (r_dz) begin
            w_q = '1;
            w_r = r_ext_a;
        end else if (r_ovf) begin
            w_q = r_ext_a;
            w_r = '0;
        end
        w_sel = r_is_rem ? w_r : w_q;
        w_res = r_word ? sext32(w_sel[31:0]) : w_sel;
    end

    assign bus.in_ready  = (r_state == YSYX_22050133_ST_IDLE) && !rst;
    assign bus.out_valid = (r_state == YSYX_22050133_ST_DONE) && !rst;
    assign bus.result    = bus.out_valid ? w_res : '0;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_ysyx_22050133_div.sv
// Scoreboard bench for ysyx_22050133_div: directed corner cases plus random ops vs an arithmetic model.
module tb_ysyx_22050133_div;
    import ysyx_22050133_div_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    div_state_e dbg_state;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];
    int          acc_cyc = 0;
    logic        prev_ov = 1'b0;
    logic [63:0] mon_exp;
    int          mon_lat;

    ysyx_22050133_div_if #(.XLEN(64)) bus ();

    ysyx_22050133_div #(.XLEN(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%016h required 0x%016h", name, act, req);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_div(input logic [1:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic        is_signed, want_rem;
        logic [31:0] ua32, ub32, q32, r32;
        int          sa32, sb32;
        logic [63:0] q, r;
        longint      sa, sb;
        is_signed = (op == 2'b00) || (op == 2'b10);
        want_rem  = op[1];
        if (word) begin
            ua32 = a[31:0];
            ub32 = b[31:0];
            sa32 = $signed(ua32);
            sb32 = $signed(ub32);
            if (ub32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = ua32;
            end else if (is_signed && ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) begin
                q32 = ua32;
                r32 = 32'd0;
            end else if (is_signed) begin
                q32 = 32'(sa32 / sb32);
                r32 = 32'(sa32 % sb32);
            end else begin
                q32 = ua32 / ub32;
                r32 = ua32 % ub32;
            end
            return want_rem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end
        sa = $signed(a);
        sb = $signed(b);
        if (b == 64'd0) begin
            q = '1;
            r = a;
        end else if (is_signed && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a;
            r = 64'd0;
        end else if (is_signed) begin
            q = 64'(sa / sb);
            r = 64'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return want_rem ? r : q;
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic word,
                                       input logic [63:0] a, input logic [63:0] b);
        logic is_signed, zero, ovf;
        is_signed = (op == 2'b00) || (op == 2'b10);
        zero = word ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = is_signed && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                  : (a == 64'h8000_0000_0000_0000 && b == '1));
`ifdef YSYX_22050133_DIV_EARLY_EN
        if (zero || ovf) return 1;
`else
        if (zero || ovf) return word ? 33 : 65;
`endif
        return word ? 33 : 65;
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 64'($urandom_range(0, 20));
            1:       return 64'd0;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'hFFFF_FFFF_8000_0000;
            5:       return -64'($urandom_range(1, 1000));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (bus.in_valid && bus.in_ready && !bus.flush) acc_cyc = cyc;
                if (bus.out_valid && !prev_ov) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        mon_lat = lat_q.pop_front();
                        check("result", bus.result, mon_exp);
                        check("latency", 64'(cyc - acc_cyc), 64'(mon_lat));
                    end
                end
                prev_ov = bus.out_valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b);
        bit ok;
        @(posedge clk); #1;
        bus.op       = op;
        bus.word     = word;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = {$urandom, $urandom};
        bus.op       = 2'($urandom_range(0, 3));
        bus.word     = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        logic [63:0] e;
        bit          ok;
        e = ref_div(op, word, a, b);
        exp_q.push_back(e);
        lat_q.push_back(exp_latency(op, word, a, b));
        issue(op, word, a, b);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", 64'(ok), 64'd1);
        for (int k = 0; k < hold; k++) begin
            check("hold_result", bus.result, e);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);
        check("idle_result_zero", bus.result, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = YSYX_22050133_OP_DIVU;
        bus.word      = 1'b0;
        bus.dividend  = 64'd100;
        bus.divisor   = 64'd7;
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

        run_op(YSYX_22050133_OP_DIVU, 1'b0, 64'd100, 64'd7, 0);
        run_op(YSYX_22050133_OP_REMU, 1'b0, 64'd100, 64'd7, 1);
        run_op(YSYX_22050133_OP_DIV,  1'b0, -64'd7, 64'd2, 0);
        run_op(YSYX_22050133_OP_REM,  1'b0, -64'd7, 64'd2, 0);
        run_op(YSYX_22050133_OP_DIV,  1'b1, 64'h0000_0000_8000_0000, '1, 0);
        run_op(YSYX_22050133_OP_DIVU, 1'b0, 64'd5, 64'd0, 0);
        run_op(YSYX_22050133_OP_REMU, 1'b0, 64'd5, 64'd0, 0);
        run_op(YSYX_22050133_OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 0);
        run_op(YSYX_22050133_OP_REMU, 1'b1, 64'h1234_5678_FFFF_FFF0, 64'd7, 0);
        run_op(YSYX_22050133_OP_DIV,  1'b0, 64'd12345, -64'd3, 10);

        // Flush on the 20th BUSY cycle: the op must vanish.
        issue(YSYX_22050133_OP_DIVU, 1'b0, 64'd1000, 64'd7);
        repeat (19) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (80) @(negedge clk);
        run_op(YSYX_22050133_OP_DIVU, 1'b0, 64'd9, 64'd3, 0);

        // Reset mid-BUSY, with other controls asserted: the op must vanish.
        issue(YSYX_22050133_OP_DIV, 1'b0, -64'd1000, 64'd7);
        repeat (10) @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("busy_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("busy_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("busy_rst_result", bus.result, 64'd0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("busy_rst_idle", 64'(bus.in_ready), 64'd1);
        repeat (80) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   rnd_operand(), rnd_operand(), $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
